// File: rtl/operand_scoreboard_porc2_if.sv
// Bundle of every non-clock signal of operand_scoreboard_porc2.
//   slave  : the scheduler side (takes decode/writeback/control inputs, drives issue slot).
//   master : the environment side (decode, execute, writeback and branch unit).
// Optional: SCOREBOARD_STALL_COUNT_EN adds stall_count[15:0].
interface operand_scoreboard_porc2_if #(
  parameter int unsigned DATABITWIDTH = 16,
  parameter int unsigned REGCOUNT     = 16
);
  // Decode side
  logic                    in_valid;
  logic                    in_ready;
  logic [15:0]             in_instruction;
  logic [3:0]              in_a_addr;
  logic [3:0]              in_b_addr;
  logic                    in_read_a;
  logic                    in_read_b;
  logic                    in_write_a;
  logic                    in_mark_a_dirty;
  logic                    in_branch;
  logic [DATABITWIDTH-1:0] in_immediate;
  // Execute side
  logic                    out_valid;
  logic                    out_ready;
  logic [15:0]             out_instruction;
  logic [3:0]              out_a_addr;
  logic [3:0]              out_b_addr;
  logic                    out_write_a;
  logic [DATABITWIDTH-1:0] out_immediate;
  // Writeback, branch and flush
  logic                    wb0_valid;
  logic [3:0]              wb0_addr;
  logic                    wb1_valid;
  logic [3:0]              wb1_addr;
  logic                    branch_resolve;
  logic                    flush;
  logic [REGCOUNT-1:0]     dirty_vector;
`ifdef SCOREBOARD_STALL_COUNT_EN
  logic [15:0]             stall_count;
`endif

  modport slave (
    input  in_valid, in_instruction, in_a_addr, in_b_addr, in_read_a, in_read_b,
    input  in_write_a, in_mark_a_dirty, in_branch, in_immediate, out_ready,
    input  wb0_valid, wb0_addr, wb1_valid, wb1_addr, branch_resolve, flush,
    output in_ready, out_valid, out_instruction, out_a_addr, out_b_addr, out_write_a,
    output out_immediate, dirty_vector
`ifdef SCOREBOARD_STALL_COUNT_EN
    , output stall_count
`endif
  );

  modport master (
    output in_valid, in_instruction, in_a_addr, in_b_addr, in_read_a, in_read_b,
    output in_write_a, in_mark_a_dirty, in_branch, in_immediate, out_ready,
    output wb0_valid, wb0_addr, wb1_valid, wb1_addr, branch_resolve, flush,
    input  in_ready, out_valid, out_instruction, out_a_addr, out_b_addr, out_write_a,
    input  out_immediate, dirty_vector
`ifdef SCOREBOARD_STALL_COUNT_EN
    , input stall_count
`endif
  );
endinterface

// File: rtl/operand_scoreboard_porc2.sv
// Issue scheduler between decode and execute. Tracks per-register dirty bits for
// long-latency writers, stalls decoded instructions on operand hazards, serialises
// issue behind branches and presents a single registered issue slot.
// Ports:
//   clk        clock
//   clk_en     clock enable; all state holds while low
//   async_rst  asynchronous active-high reset
//   bus        operand_scoreboard_porc2_if.slave (decode/execute handshakes,
//              writeback clears, branch_resolve, flush, dirty_vector)
// Optional: define SCOREBOARD_STALL_COUNT_EN to add a saturating stall counter
// (bus.stall_count) counting RUN-state cycles where decode is valid but held off.
module operand_scoreboard_porc2 #(
  parameter int unsigned DATABITWIDTH = 16,
  parameter int unsigned REGCOUNT     = 16
) (
  input logic                  clk,
  input logic                  clk_en,
  input logic                  async_rst,
  operand_scoreboard_porc2_if.slave bus
);

  localparam logic [0:0] StRun        = 1'b0;
  localparam logic [0:0] StBranchWait = 1'b1;

  localparam logic [REGCOUNT-1:0] OneHot0 = {{(REGCOUNT-1){1'b0}}, 1'b1};

  logic [0:0]              state_q, state_d;
  logic [REGCOUNT-1:0]     dirty_q, dirty_d;
  logic [REGCOUNT-1:0]     clr, set_mask, dirty_eff;
  logic                    out_valid_q, out_valid_d;
  logic [15:0]             out_instruction_q;
  logic [3:0]              out_a_addr_q, out_b_addr_q;
  logic                    out_write_a_q;
  logic [DATABITWIDTH-1:0] out_immediate_q;
  logic                    hazard, in_ready, issue;

  always_comb begin
    clr = '0;
    if (bus.wb0_valid) clr = clr | (OneHot0 << bus.wb0_addr);
    if (bus.wb1_valid) clr = clr | (OneHot0 << bus.wb1_addr);
    // Same-cycle writeback is visible to the hazard check.
    dirty_eff = dirty_q & ~clr;
    hazard = ((bus.in_read_a | bus.in_write_a) & dirty_eff[bus.in_a_addr]) |
             (bus.in_read_b & dirty_eff[bus.in_b_addr]);
    // Held low for the whole reset assertion.
    in_ready = ~async_rst & (state_q == StRun) & ~bus.flush & ~hazard &
               (~out_valid_q | bus.out_ready);
    issue = bus.in_valid & in_ready;

    set_mask = '0;
    if (issue && bus.in_write_a && bus.in_mark_a_dirty) set_mask = OneHot0 << bus.in_a_addr;
    // Set is ORed after the clear, so a new writer wins over a retiring one.
    dirty_d = dirty_eff | set_mask;

    out_valid_d = out_valid_q;
    if (bus.flush)          out_valid_d = 1'b0;
    else if (issue)         out_valid_d = 1'b1;
    else if (bus.out_ready) out_valid_d = 1'b0;

    state_d = state_q;
    unique case (state_q)
      StRun:        if (issue && bus.in_branch) state_d = StBranchWait;
      StBranchWait: if (bus.branch_resolve || bus.flush) state_d = StRun;
      default:      state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q           <= StRun;
      dirty_q           <= '0;
      out_valid_q       <= 1'b0;
      out_instruction_q <= '0;
      out_a_addr_q      <= '0;
      out_b_addr_q      <= '0;
      out_write_a_q     <= 1'b0;
      out_immediate_q   <= '0;
    end else if (clk_en) begin
      state_q     <= state_d;
      dirty_q     <= dirty_d;
      out_valid_q <= out_valid_d;
      if (issue) begin
        out_instruction_q <= bus.in_instruction;
        out_a_addr_q      <= bus.in_a_addr;
        out_b_addr_q      <= bus.in_b_addr;
        out_write_a_q     <= bus.in_write_a;
        out_immediate_q   <= bus.in_immediate;
      end
    end
  end

`ifdef SCOREBOARD_STALL_COUNT_EN
  logic [15:0] stall_count_q;

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      stall_count_q <= '0;
    end else if (clk_en && bus.in_valid && !in_ready && (state_q == StRun) &&
                 (stall_count_q != 16'hFFFF)) begin
      stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign bus.stall_count = stall_count_q;
`endif

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_instruction = out_instruction_q;
  assign bus.out_a_addr      = out_a_addr_q;
  assign bus.out_b_addr      = out_b_addr_q;
  assign bus.out_write_a     = out_write_a_q;
  assign bus.out_immediate   = out_immediate_q;
  assign bus.dirty_vector    = dirty_q;

endmodule

// File: tb/tb_operand_scoreboard_porc2.sv
module tb_operand_scoreboard_porc2;

  typedef struct packed {
    logic [15:0] instr;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        ra;
    logic        rb;
    logic        wa;
    logic        md;
    logic        br;
    logic [15:0] imm;
  } insn_t;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic async_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  insn_t exp_q[$];

  operand_scoreboard_porc2_if bus ();

  operand_scoreboard_porc2 dut (
    .clk       (clk),
    .clk_en    (clk_en),
    .async_rst (async_rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted instruction must appear in the issue slot in order.
  always @(negedge clk) begin
    if (!async_rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL slot_unexpected got instr=%h with nothing expected", bus.out_instruction);
      end else begin
        insn_t e;
        e = exp_q.pop_front();
        if ({bus.out_instruction, bus.out_a_addr, bus.out_b_addr, bus.out_write_a,
             bus.out_immediate} !== {e.instr, e.a, e.b, e.wa, e.imm}) begin
          errors++;
          $display("FAIL slot_fields got %h/%h/%h/%b/%h want %h/%h/%h/%b/%h",
                   bus.out_instruction, bus.out_a_addr, bus.out_b_addr, bus.out_write_a,
                   bus.out_immediate, e.instr, e.a, e.b, e.wa, e.imm);
        end
      end
    end
  end

  function automatic insn_t mk(input logic [15:0] instr, input logic [3:0] a, input logic [3:0] b,
                               input logic ra, input logic rb, input logic wa, input logic md,
                               input logic br);
    insn_t t;
    t.instr = instr; t.a = a; t.b = b; t.ra = ra; t.rb = rb;
    t.wa = wa; t.md = md; t.br = br; t.imm = ~instr;
    return t;
  endfunction

  task automatic drive(input insn_t t);
    bus.in_instruction  = t.instr;
    bus.in_a_addr       = t.a;
    bus.in_b_addr       = t.b;
    bus.in_read_a       = t.ra;
    bus.in_read_b       = t.rb;
    bus.in_write_a      = t.wa;
    bus.in_mark_a_dirty = t.md;
    bus.in_branch       = t.br;
    bus.in_immediate    = t.imm;
  endtask

  // Offers t until accepted; returns with time at posedge+1 after the issue edge.
  task automatic issue_insn(input insn_t t, output int stalls);
    stalls = 0;
    drive(t);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(t);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
      stalls++;
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL issue_timeout instr=%h never accepted within 50 cycles", t.instr);
    bus.in_valid = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive(mk(16'h1111, 4'd1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    bus.in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
    checks++;
    if (bus.dirty_vector !== 16'h0000) begin errors++; $display("FAIL rst_dirty got %h want 0000", bus.dirty_vector); end
    checks++;
    if ({bus.out_instruction, bus.out_immediate} !== 32'h0) begin
      errors++; $display("FAIL rst_fields got %h/%h want 0/0", bus.out_instruction, bus.out_immediate);
    end
`ifdef SCOREBOARD_STALL_COUNT_EN
    checks++;
    if (bus.stall_count !== 16'h0) begin errors++; $display("FAIL rst_stall_count got %h want 0", bus.stall_count); end
`endif
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    async_rst = 1'b0;
    cycle();
  endtask

  task automatic test_back_to_back();
    int n;
    for (int i = 0; i < 5; i++) begin
      issue_insn(mk(16'h2000 + 16'(i), 4'(i + 1), 4'(i + 6), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), n);
      checks++;
      if (n != 0) begin errors++; $display("FAIL b2b_stall[%0d] got %0d want 0", i, n); end
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid[%0d] got %b want 1", i, bus.out_valid); end
    end
    checks++;
    if (bus.dirty_vector !== 16'h0000) begin errors++; $display("FAIL b2b_dirty got %h want 0000", bus.dirty_vector); end
    cycle(); cycle();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_load_hazard();
    int n;
    insn_t use_t;
`ifdef SCOREBOARD_STALL_COUNT_EN
    logic [15:0] sc0;
`endif
    issue_insn(mk(16'h3003, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), n);
    checks++;
    if (bus.dirty_vector !== 16'h0008) begin errors++; $display("FAIL ld_dirty_set got %h want 0008", bus.dirty_vector); end
    use_t = mk(16'h3104, 4'd4, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(use_t);
`ifdef SCOREBOARD_STALL_COUNT_EN
    sc0 = bus.stall_count;
`endif
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL ld_stall[%0d] in_ready got %b want 0", i, bus.in_ready); end
      @(posedge clk); #1;
    end
`ifdef SCOREBOARD_STALL_COUNT_EN
    checks++;
    if (bus.stall_count - sc0 !== 16'd3) begin
      errors++; $display("FAIL ld_stall_count got %0d want 3", bus.stall_count - sc0);
    end
`endif
    bus.wb0_valid = 1'b1;
    bus.wb0_addr  = 4'd3;
    issue_insn(use_t, n);
    bus.wb0_valid = 1'b0;
    checks++;
    if (n != 0) begin errors++; $display("FAIL ld_bypass_issue stalls got %0d want 0", n); end
    checks++;
    if (bus.dirty_vector !== 16'h0000) begin errors++; $display("FAIL ld_dirty_clr got %h want 0000", bus.dirty_vector); end
  endtask

  task automatic test_wb_set_priority();
    int n;
    issue_insn(mk(16'h4005, 4'd5, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), n);
    bus.wb1_valid = 1'b1;
    bus.wb1_addr  = 4'd5;
    issue_insn(mk(16'h4105, 4'd5, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0), n);
    bus.wb1_valid = 1'b0;
    checks++;
    if (n != 0) begin errors++; $display("FAIL wbset_issue stalls got %0d want 0", n); end
    checks++;
    if (bus.dirty_vector !== 16'h0020) begin errors++; $display("FAIL wbset_dirty got %h want 0020", bus.dirty_vector); end
    // Both ports on the same register, then a writeback to a clean register.
    bus.wb0_valid = 1'b1; bus.wb0_addr = 4'd5;
    bus.wb1_valid = 1'b1; bus.wb1_addr = 4'd5;
    cycle();
    bus.wb0_addr = 4'd7; bus.wb1_valid = 1'b0;
    cycle();
    bus.wb0_valid = 1'b0;
    checks++;
    if (bus.dirty_vector !== 16'h0000) begin errors++; $display("FAIL wbdual_dirty got %h want 0000", bus.dirty_vector); end
  endtask

  task automatic test_branch();
    int n;
    insn_t t;
    issue_insn(mk(16'h5000, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), n);
    t = mk(16'h5101, 4'd1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(t);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL br_wait[%0d] in_ready got %b want 0", i, bus.in_ready); end
      @(posedge clk); #1;
    end
    bus.branch_resolve = 1'b1;
    cycle();
    bus.branch_resolve = 1'b0;
    issue_insn(t, n);
    checks++;
    if (n != 0) begin errors++; $display("FAIL br_resume stalls got %0d want 0", n); end
    // Resolve pulse while already running must not disturb issue.
    bus.branch_resolve = 1'b1;
    cycle();
    bus.branch_resolve = 1'b0;
    issue_insn(mk(16'h5202, 4'd2, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0), n);
    checks++;
    if (n != 0) begin errors++; $display("FAIL br_resolve_in_run stalls got %0d want 0", n); end
    cycle();
  endtask

  task automatic test_backpressure();
    int n;
    insn_t ta, tb2;
    ta  = mk(16'h6001, 4'd1, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tb2 = mk(16'h6102, 4'd2, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    issue_insn(ta, n);
    drive(tb2);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_instruction !== ta.instr || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got instr=%h ready=%b want %h/0", i, bus.out_instruction,
                 bus.in_ready, ta.instr);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    issue_insn(tb2, n);
    checks++;
    if (n != 0) begin errors++; $display("FAIL bp_release stalls got %0d want 0", n); end
    checks++;
    if (bus.out_instruction !== tb2.instr) begin
      errors++; $display("FAIL bp_new_slot got %h want %h", bus.out_instruction, tb2.instr);
    end
    cycle();
  endtask

  task automatic test_flush();
    int n;
    insn_t drop;
    bus.out_ready = 1'b0;
    issue_insn(mk(16'h7002, 4'd2, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), n);
    drive(mk(16'h7103, 4'd3, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", bus.in_ready); end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    drop = exp_q.pop_front();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", bus.out_valid); end
    checks++;
    if (bus.dirty_vector !== 16'h0004) begin errors++; $display("FAIL flush_dirty got %h want 0004", bus.dirty_vector); end
    bus.out_ready = 1'b1;
    // Flush out of BRANCH_WAIT together with a writeback.
    issue_insn(mk(16'h7200, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), n);
    cycle();
    bus.flush = 1'b1;
    bus.wb0_valid = 1'b1; bus.wb0_addr = 4'd2;
    cycle();
    bus.flush = 1'b0; bus.wb0_valid = 1'b0;
    checks++;
    if (bus.dirty_vector !== 16'h0000) begin errors++; $display("FAIL flush_wb_dirty got %h want 0000", bus.dirty_vector); end
    issue_insn(mk(16'h7304, 4'd4, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), n);
    checks++;
    if (n != 0) begin errors++; $display("FAIL flush_leaves_bw stalls got %0d want 0", n); end
    cycle();
  endtask

  task automatic test_reset_mid();
    int n;
    bus.out_ready = 1'b0;
    issue_insn(mk(16'h8009, 4'd9, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), n);
    #2;
    async_rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.dirty_vector !== 16'h0000 || bus.out_instruction !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid got valid=%b dirty=%h instr=%h want 0/0000/0000", bus.out_valid,
               bus.dirty_vector, bus.out_instruction);
    end
    exp_q.delete();
    @(posedge clk); #1;
    async_rst = 1'b0;
    bus.out_ready = 1'b1;
    cycle();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.wb0_valid = 1'b0; bus.wb0_addr = 4'd0;
    bus.wb1_valid = 1'b0; bus.wb1_addr = 4'd0;
    bus.branch_resolve = 1'b0;
    bus.flush = 1'b0;
    drive(mk(16'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    test_reset();
    test_back_to_back();
    test_load_hazard();
    test_wb_set_priority();
    test_branch();
    test_backpressure();
    test_flush();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
